// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator for the Y86-64 core: decodes one operation, issues a
// bounds-checked read/write over valid/ready and returns valM with a timeout.
module mem_access_ctrl #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned TIMEOUT   = 16,
   parameter int unsigned CNT_W     = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_code,
   input  logic [63:0] val_e,
   input  logic [63:0] val_a,
   input  logic [63:0] val_p,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_we,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_code,
   output logic [63:0] val_m,
   output logic        bad_mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               dec_mem, dec_we, dec_bad;
   logic [63:0]        dec_addr, dec_wdata;
   logic               accept, cnt_last;

   always_comb begin
      dec_mem   = 1'b0;
      dec_we    = 1'b0;
      dec_addr  = val_e;
      dec_wdata = val_a;
      case (in_code)
         4'd4, 4'd10: begin dec_mem = 1'b1; dec_we = 1'b1; end
         4'd8:        begin dec_mem = 1'b1; dec_we = 1'b1; dec_wdata = val_p; end
         4'd5:        dec_mem = 1'b1;
         4'd9, 4'd11: begin dec_mem = 1'b1; dec_addr = val_a; end
         default:     dec_mem = 1'b0;
      endcase
      dec_bad = dec_mem && (dec_addr >= 64'(MEM_WORDS));
   end

   assign accept   = (state == IDLE) && in_valid;
   assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = (dec_mem && !dec_bad) ? ISSUE : OUT;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid || cnt_last) state_nxt = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A response on the final timeout cycle takes priority over the timeout.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt           <= '0;
         out_code      <= '0;
         mem_req_we    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         val_m         <= '0;
         bad_mem       <= 1'b0;
      end else begin
         if (accept) begin
            out_code      <= in_code;
            mem_req_addr  <= dec_addr;
            mem_req_wdata <= dec_wdata;
            mem_req_we    <= dec_we;
            if (!dec_mem || dec_bad) begin
               val_m   <= '0;
               bad_mem <= dec_bad;
            end
         end
         if (state == ISSUE && mem_req_ready) cnt <= '0;
         if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
            if (mem_rsp_valid) begin
               val_m   <= mem_req_we ? 64'd0 : mem_rsp_data;
               bad_mem <= 1'b0;
            end else if (cnt_last) begin
               val_m   <= '0;
               bad_mem <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl plus reset and late-response sequences.
module tb_mem_access_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_code = '0;
   logic [63:0] val_e = '0, val_a = '0, val_p = '0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_we;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic        mem_rsp_valid = 1'b0;
   logic [63:0] mem_rsp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_code;
   logic [63:0] val_m;
   logic        bad_mem;

   int tests = 0;
   int failed = 0;

   mem_access_ctrl #(.MEM_WORDS(1024), .TIMEOUT(16), .CNT_W(5)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .val_e(val_e), .val_a(val_a), .val_p(val_p),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .val_m(val_m), .bad_mem(bad_mem)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  code;
      logic [63:0] ve, va, vp;
      int          ready_dly;   // cycles mem_req_ready stays low
      int          rsp_dly;     // WAIT cycle index of the response, 255 = never
      logic [63:0] rsp_data;
      int          out_hold;    // cycles out_ready stays low
      bit          exp_req, exp_we;
      logic [63:0] exp_addr, exp_wdata;
      int          exp_lat;
      logic [63:0] exp_valm;
      bit          exp_bad;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_op(input int idx, input vec_t v);
      int  cyc, n_req, wait_cnt;
      bit  wait_active, done;
      string tag;
      tag = $sformatf("v%0d", idx);
      chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_code = v.code; val_e = v.ve; val_a = v.va; val_p = v.vp;
      mem_rsp_data = v.rsp_data;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      cyc = 1; n_req = 0; wait_cnt = 0; wait_active = 0; done = 0;
      while (!done && cyc < 100) begin
         if (out_valid) done = 1;
         else begin
            if (wait_active) begin
               mem_rsp_valid = (wait_cnt == v.rsp_dly);
               wait_cnt++;
            end else mem_rsp_valid = 1'b0;
            if (mem_req_valid) begin
               n_req++;
               chk({tag, " req_addr"}, mem_req_addr, v.exp_addr);
               chk({tag, " req_we"}, 64'(mem_req_we), 64'(v.exp_we));
               if (v.exp_we) chk({tag, " req_wdata"}, mem_req_wdata, v.exp_wdata);
               mem_req_ready = (n_req > v.ready_dly);
               if (mem_req_ready) wait_active = 1;
            end else mem_req_ready = 1'b0;
            @(negedge clock);
            cyc++;
         end
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      if (!done) begin
         tests++; failed++;
         $display("FAIL %s out_valid_timeout: got none expected out_valid within 100 cycles", tag);
      end
      chk({tag, " latency"}, 64'(cyc), 64'(v.exp_lat));
      chk({tag, " req_cycles"}, 64'(n_req), v.exp_req ? 64'(v.ready_dly + 1) : 64'd0);
      chk({tag, " val_m"}, val_m, v.exp_valm);
      chk({tag, " bad_mem"}, 64'(bad_mem), 64'(v.exp_bad));
      chk({tag, " out_code"}, 64'(out_code), 64'(v.code));
      for (int h = 0; h < v.out_hold; h++) begin
         mem_rsp_valid = 1'b1; mem_rsp_data = 64'hDEAD;
         @(negedge clock);
         chk({tag, " hold_out_valid"}, 64'(out_valid), 64'd1);
         chk({tag, " hold_in_ready"}, 64'(in_ready), 64'd0);
         chk({tag, " hold_val_m"}, val_m, v.exp_valm);
         chk({tag, " hold_out_code"}, 64'(out_code), 64'(v.code));
         chk({tag, " hold_req_valid"}, 64'(mem_req_valid), 64'd0);
      end
      mem_rsp_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk({tag, " out_valid_fall"}, 64'(out_valid), 64'd0);
      chk({tag, " in_ready_back"}, 64'(in_ready), 64'd1);
      chk({tag, " val_m_kept"}, val_m, v.exp_valm);
      chk({tag, " bad_mem_kept"}, 64'(bad_mem), 64'(v.exp_bad));
   endtask

   initial begin
      vecs[0]  = '{4'd5, 64'd7, 64'd0, 64'd0, 0, 0, 64'd70, 0, 1'b1, 1'b0, 64'd7, 64'd0, 3, 64'd70, 1'b0};
      vecs[1]  = '{4'd8, 64'd20, 64'h99, 64'h40, 4, 0, 64'h77, 0, 1'b1, 1'b1, 64'd20, 64'h40, 7, 64'd0, 1'b0};
      vecs[2]  = '{4'd11, 64'd5, 64'd1024, 64'd0, 0, 0, 64'd0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 1, 64'd0, 1'b1};
      vecs[3]  = '{4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'd0, 0, 0, 64'd0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 1, 64'd0, 1'b1};
      vecs[4]  = '{4'd0, 64'd3, 64'd3, 64'd3, 0, 0, 64'd0, 3, 1'b0, 1'b0, 64'd0, 64'd0, 1, 64'd0, 1'b0};
      vecs[5]  = '{4'd3, 64'd2000, 64'd1, 64'd1, 0, 0, 64'd0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 1, 64'd0, 1'b0};
      vecs[6]  = '{4'd10, 64'd0, 64'hAB, 64'h1, 1, 3, 64'hFFFF, 0, 1'b1, 1'b1, 64'd0, 64'hAB, 7, 64'd0, 1'b0};
      vecs[7]  = '{4'd4, 64'd1024, 64'h5, 64'd0, 0, 0, 64'd0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 1, 64'd0, 1'b1};
      vecs[8]  = '{4'd9, 64'd100, 64'd3, 64'd0, 0, 255, 64'd0, 2, 1'b1, 1'b0, 64'd3, 64'd0, 18, 64'd0, 1'b1};
      vecs[9]  = '{4'd5, 64'd1023, 64'd0, 64'd0, 0, 2, 64'h1234_5678_9ABC_DEF0, 1, 1'b1, 1'b0, 64'd1023, 64'd0, 5, 64'h1234_5678_9ABC_DEF0, 1'b0};
      vecs[10] = '{4'd9, 64'd0, 64'd9, 64'd0, 0, 15, 64'h55, 0, 1'b1, 1'b0, 64'd9, 64'd0, 18, 64'h55, 1'b0};

      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst in_ready", 64'(in_ready), 64'd1);
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst val_m", val_m, 64'd0);
      chk("rst bad_mem", 64'(bad_mem), 64'd0);
      chk("rst req_addr", mem_req_addr, 64'd0);

      for (int i = 0; i < 11; i++) run_op(i, vecs[i]);

      // stray response while idle must not create a result
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBEEF;
      @(negedge clock);
      mem_rsp_valid = 1'b0;
      chk("idle_rsp out_valid", 64'(out_valid), 64'd0);
      chk("idle_rsp val_m", val_m, 64'h55);

      // reset while a request is pending in ISSUE
      in_valid = 1'b1; in_code = 4'd5; val_e = 64'd4;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      chk("mid issue req_valid", 64'(mem_req_valid), 64'd1);
      mem_req_ready = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid rst req_valid", 64'(mem_req_valid), 64'd0);
      chk("mid rst in_ready", 64'(in_ready), 64'd1);
      chk("mid rst out_valid", 64'(out_valid), 64'd0);
      chk("mid rst val_m", val_m, 64'd0);
      chk("mid rst out_code", 64'(out_code), 64'd0);
      chk("mid rst req_addr", mem_req_addr, 64'd0);
      chk("mid rst req_we", 64'(mem_req_we), 64'd0);
      mem_rsp_valid = 1'b1; mem_rsp_data = 64'hCAFE;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk("stale rsp out_valid", 64'(out_valid), 64'd0);
         chk("stale rsp req_valid", 64'(mem_req_valid), 64'd0);
      end
      mem_rsp_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage initiator for the Y86-64 core; the requesting side of the data-memory interface.
- Accepts one memory-stage operation (icode, valE, valA, valP) per handshake and decodes it into a read or write request.
- Drives the request to the data-memory responder over a valid/ready channel, waits for the response, and returns valM and a bad-memory flag downstream.
- Adds bounds checking and a response timeout so that a stalled memory cannot hang the core.

Parameters:
- MEM_WORDS, 1024: number of 64-bit words in data memory; a valid address is < MEM_WORDS.
- TIMEOUT, 16: maximum number of cycles to wait in WAIT for a response before flagging an error.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream operation valid
- in_ready  out  1  block can accept an operation
- in_code  in  4  icode
- val_e  in  64  ALU result (valE)
- val_a  in  64  valA
- val_p  in  64  valP
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_we  out  1  1 = write, 0 = read
- mem_req_addr  out  64  word address
- mem_req_wdata  out  64  write data
- mem_rsp_valid  in  1  response or write acknowledge
- mem_rsp_data  in  64  read data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_code  out  4  icode of the completed operation
- val_m  out  64  valM
- bad_mem  out  1  memory error for this operation

Behaviour:
- Reset: all outputs are 0, state is IDLE, counter is 0. Reset asserted in any state aborts the operation, drops mem_req_valid on the next cycle, and discards any later response.
- Decode, latched on accept:
  - Write, addr = val_e, data = val_a: icode 4 (rmmovq), 10 (pushq).
  - Write, addr = val_e, data = val_p: icode 8 (call).
  - Read, addr = val_e: icode 5 (mrmovq).
  - Read, addr = val_a: icode 9 (ret), 11 (popq).
  - Every other icode is a no-op.
- States:
  - IDLE:
    - in_ready = 1.
    - Accept occurs when in_valid = 1. Latch code, address, data and we.
    - No-op goes to OUT with val_m = 0 and bad_mem = 0.
    - Address >= MEM_WORDS goes to OUT with bad_mem = 1 and val_m = 0; no request is issued.
    - Otherwise go to ISSUE.
  - ISSUE:
    - mem_req_valid = 1. Address, data and we hold stable until the request handshake.
    - When mem_req_ready = 1, go to WAIT and clear the counter.
  - WAIT:
    - mem_req_valid = 0. The counter increments every cycle.
    - When mem_rsp_valid = 1: a read latches val_m = mem_rsp_data; a write sets val_m = 0. bad_mem = 0; go to OUT.
    - When the counter reaches TIMEOUT-1 with no response: bad_mem = 1, val_m = 0; go to OUT.
    - If the response arrives on the timeout cycle, the response wins.
  - OUT:
    - out_valid = 1. out_code, val_m and bad_mem are stable.
    - When out_ready = 1, go to IDLE. out_valid falls on the next cycle; val_m and bad_mem hold their last values.
- in_ready is 0 in every state other than IDLE. There is no back-to-back accept in OUT; at most one operation is in flight.
- mem_rsp_valid is ignored outside WAIT, so a late response after a timeout is dropped.
- Best-case latency, accept to out_valid:
  - Memory operation: 3 cycles (accept, ISSUE with ready, WAIT with response).
  - No-op or bad address: 1 cycle.
- Addresses compare as unsigned 64-bit values. There is no wrap-around; 64'hFFFF_FFFF_FFFF_FFFF is out of range.

Test Plan:
- mrmovq read:
  - Stimulus: code = 5, val_e = 7, with mem_req_ready and mem_rsp_valid = 1 in the first eligible cycle, rsp data = 64'd70.
  - Required: one request with addr = 7, we = 0; out_valid 3 cycles after accept; val_m = 70; bad_mem = 0.
- call write with memory backpressure:
  - Stimulus: code = 8, val_e = 20, val_p = 64'h40; mem_req_ready held low for 4 cycles.
  - Required: mem_req_valid held 5 cycles with addr = 20, wdata = 64'h40, we = 1 stable; val_m = 0.
- Bad addresses:
  - Stimulus: popq with code = 11, val_a = 1024; then rmmovq with code = 4, val_e = 64'hFFFF_FFFF_FFFF_FFFF.
  - Required: no mem_req_valid for either; out_valid 1 cycle after each accept; bad_mem = 1.
- Timeout:
  - Stimulus: code = 9, val_a = 3; memory accepts the request and never responds.
  - Required: out_valid with bad_mem = 1 exactly TIMEOUT cycles after entering WAIT. A response injected 2 cycles later is ignored, and the next op returns correct data.
- Output backpressure and no-op:
  - Stimulus: code = 0 (nop); out_ready low for 3 cycles.
  - Required: no request issued; out_valid, out_code = 0 and val_m = 0 held stable; in_ready = 0 until out_ready.
- Reset mid-operation:
  - Stimulus: assert reset in ISSUE.
  - Required: the next cycle shows mem_req_valid = 0, all outputs 0 and in_ready = 1. A stale rsp_valid afterwards produces no out_valid.
